// File: rtl/mem_pkg.sv
// mem_pkg: imem request/response packet shared by the core and its memories
package mem_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_type_t;
  typedef struct packed {
    mem_type_t   mtype;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_pkt_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with in-flight tracking and a fetch queue
module fetch_unit
  import mem_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [N_BITS-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_vld,
  input  logic              imem_req_rdy,
  output mem_pkt_t          imem_req,
  input  logic              imem_rsp_vld,
  output logic              imem_rsp_rdy,
  input  mem_pkt_t          imem_rsp,
  input  logic              redirect_vld,
  input  logic [N_BITS-1:0] redirect_pc,
  output logic              instr_vld,
  input  logic              instr_rdy,
  output logic [N_BITS-1:0] instr,
  output logic [N_BITS-1:0] instr_pc,
  output logic [N_BITS-1:0] instr_pc_plus4
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  logic [N_BITS-1:0] fetch_pc;
  logic [N_BITS-1:0] if_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] if_stale;
  logic [IW-1:0] if_wp, if_rp;
  logic [N_BITS-1:0] fq_instr [FQ_DEPTH];
  logic [N_BITS-1:0] fq_pc [FQ_DEPTH];
  logic [AW-1:0] fq_wp, fq_rp;
  logic [CW-1:0] inflight_cnt, fq_cnt;
  logic req_fire, rsp_fire, fq_push, deq;
  logic unused_ok;
  function automatic logic [IW-1:0] if_next(input logic [IW-1:0] p);
    return p == IW'(MAX_OUTSTANDING - 1) ? '0 : p + IW'(1);
  endfunction
  assign imem_req_vld = rst_n & ~redirect_vld & (inflight_cnt < CW'(MAX_OUTSTANDING)) &
                        ((CW+1)'(inflight_cnt) + (CW+1)'(fq_cnt) < (CW+1)'(FQ_DEPTH));
  assign imem_req = '{mtype: READ, addr: fetch_pc, len: 2'b00, data: '0};
  assign imem_rsp_rdy = rst_n;
  assign req_fire = imem_req_vld & imem_req_rdy;
  assign rsp_fire = imem_rsp_vld & imem_rsp_rdy;
  assign fq_push = rsp_fire & ~if_stale[if_rp] & ~redirect_vld;
  assign instr_vld = rst_n & ~redirect_vld & (fq_cnt != '0);
  assign deq = instr_vld & instr_rdy;
  assign instr = instr_vld ? fq_instr[fq_rp] : '0;
  assign instr_pc = instr_vld ? fq_pc[fq_rp] : '0;
  assign instr_pc_plus4 = instr_vld ? fq_pc[fq_rp] + N_BITS'(4) : '0;
  assign unused_ok = ^{imem_rsp.mtype, imem_rsp.addr, imem_rsp.len, redirect_pc[1:0]};
  // in-flight payload: record the pc of each issued read, a redirect poisons everything in flight
  always_ff @(posedge clk) begin
    if (req_fire) if_pc[if_wp] <= fetch_pc;
    if (redirect_vld) if_stale <= '1;
    else if (req_fire) if_stale[if_wp] <= 1'b0;
  end
  // fetch-queue payload: capture the instruction alongside the pc it was fetched from
  always_ff @(posedge clk) begin
    if (fq_push) begin
      fq_instr[fq_wp] <= imem_rsp.data;
      fq_pc[fq_wp] <= if_pc[if_rp];
    end
  end
  // control state: fetch pc, fifo pointers and occupancy counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      if_wp <= '0;
      if_rp <= '0;
      fq_wp <= '0;
      fq_rp <= '0;
      inflight_cnt <= '0;
      fq_cnt <= '0;
    end else begin
      fetch_pc <= redirect_vld ? {redirect_pc[N_BITS-1:2], 2'b00} :
                  req_fire ? fetch_pc + N_BITS'(4) : fetch_pc;
      if_wp <= req_fire ? if_next(if_wp) : if_wp;
      if_rp <= rsp_fire ? if_next(if_rp) : if_rp;
      inflight_cnt <= inflight_cnt + CW'(req_fire) - CW'(rsp_fire);
      fq_wp <= redirect_vld ? '0 : fq_wp + AW'(fq_push);
      fq_rp <= redirect_vld ? '0 : fq_rp + AW'(deq);
      fq_cnt <= redirect_vld ? '0 : fq_cnt + CW'(fq_push) - CW'(deq);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table plus scoreboard against a latency-configurable imem model
module tb_fetch_unit;
  import mem_pkg::*;
  logic clk, rst_n, imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
  logic redirect_vld, instr_vld, instr_rdy;
  mem_pkt_t imem_req, imem_rsp;
  logic [31:0] redirect_pc, instr, instr_pc, instr_pc_plus4;
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req(imem_req),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_rdy(imem_rsp_rdy), .imem_rsp(imem_rsp),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .instr_vld(instr_vld), .instr_rdy(instr_rdy), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  typedef struct {logic [31:0] pc; logic stale; int due;} infl_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
  typedef struct packed {
    logic rst_n; logic rdy; logic exp_req; logic [31:0] exp_addr; logic exp_iv; logic [31:0] exp_pc;
  } vec_t;
  infl_t mem_q[$];
  exp_t sb[$];
  logic [31:0] req_log[$], deq_log[$], p4_log[$];
  vec_t tbl [13];
  int checks = 0, errors = 0, cyc = 0, lat = 1, n_deq = 0, stale_drops = 0;
  logic [31:0] exp_fetch_pc = 0;
  logic obs_req, obs_iv, obs_rsp_fire;
  logic [31:0] obs_addr, obs_pc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return i < q.size() ? q[i] : 32'hDEAD_BEEF;
  endfunction
  task automatic clear_logs();
    req_log.delete();
    deq_log.delete();
    p4_log.delete();
  endtask
  task automatic step();
    logic exp_req, exp_iv;
    infl_t h;
    exp_t e;
    imem_rsp_vld = mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_rsp = '{mtype: READ, addr: '0, len: 2'b00,
                 data: imem_rsp_vld ? mem_q[0].pc ^ 32'hA5A5_0000 : 32'h0};
    @(negedge clk);
    obs_req = imem_req_vld; obs_addr = imem_req.addr; obs_iv = instr_vld; obs_pc = instr_pc;
    obs_rsp_fire = imem_rsp_vld & imem_rsp_rdy;
    exp_req = rst_n & ~redirect_vld & (mem_q.size() < 4) & (mem_q.size() + sb.size() < 4);
    exp_iv = rst_n & ~redirect_vld & (sb.size() > 0);
    chk("req_vld", {31'b0, imem_req_vld}, {31'b0, exp_req});
    chk("instr_vld", {31'b0, instr_vld}, {31'b0, exp_iv});
    chk("rsp_rdy", {31'b0, imem_rsp_rdy}, {31'b0, rst_n});
    if (instr_vld && instr_rdy) begin
      n_deq++;
      deq_log.push_back(instr_pc);
      p4_log.push_back(instr_pc_plus4);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr actual_pc=%h required=none", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_pc_plus4", instr_pc_plus4, e.pc + 32'd4);
      end
    end
    if (obs_rsp_fire) begin
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_without_req actual=1 required=0");
      end else begin
        h = mem_q.pop_front();
        if (!h.stale && !redirect_vld) sb.push_back('{h.pc ^ 32'hA5A5_0000, h.pc});
        else stale_drops++;
      end
    end
    if (imem_req_vld && imem_req_rdy) begin
      chk("req_addr", imem_req.addr, exp_fetch_pc);
      req_log.push_back(imem_req.addr);
      mem_q.push_back('{exp_fetch_pc, 1'b0, cyc + lat});
      exp_fetch_pc += 32'd4;
    end
    if (!rst_n) begin
      mem_q.delete();
      sb.delete();
      exp_fetch_pc = 32'h0;
    end else if (redirect_vld) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      sb.delete();
      exp_fetch_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic redir_step(input logic [31:0] pc);
    redirect_vld = 1'b1;
    redirect_pc = pc;
    step();
    redirect_vld = 1'b0;
  endtask
  initial begin
    rst_n = 0; instr_rdy = 0; imem_req_rdy = 1; redirect_vld = 0; redirect_pc = '0;
    imem_rsp_vld = 0; imem_rsp = '0;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n;
      instr_rdy = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_req_vld", i), {31'b0, obs_req}, {31'b0, tbl[i].exp_req});
      chk($sformatf("vec%0d_addr", i), obs_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_instr_vld", i), {31'b0, obs_iv}, {31'b0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) chk($sformatf("vec%0d_pc", i), obs_pc, tbl[i].exp_pc);
    end
    n_deq = 0;
    repeat (20) step();
    chk("stream_rate", n_deq, 20);
    lat = 3;
    redir_step(32'h20);
    repeat (3) step();
    clear_logs();
    stale_drops = 0;
    redir_step(32'h103);
    chk("t4_rsp_at_redirect", {31'b0, obs_rsp_fire}, 32'd1);
    repeat (12) step();
    chk("t4_first_req", qget(req_log, 0), 32'h100);
    chk("t4_first_pc", qget(deq_log, 0), 32'h100);
    chk("t4_second_pc", qget(deq_log, 1), 32'h104);
    chk("t4_stale_drops", stale_drops, 3);
    lat = 1;
    repeat (6) step();
    clear_logs();
    redir_step(32'h200);
    chk("t5_rsp_fire", {31'b0, obs_rsp_fire}, 32'd1);
    chk("t5_instr_vld", {31'b0, obs_iv}, 32'd0);
    chk("t5_req_vld", {31'b0, obs_req}, 32'd0);
    repeat (6) step();
    chk("t5_next_req", qget(req_log, 0), 32'h200);
    chk("t5_next_pc", qget(deq_log, 0), 32'h200);
    clear_logs();
    redir_step(32'hFFFF_FFF8);
    repeat (8) step();
    chk("t6_req0", qget(req_log, 0), 32'hFFFF_FFF8);
    chk("t6_req1", qget(req_log, 1), 32'hFFFF_FFFC);
    chk("t6_req2", qget(req_log, 2), 32'h0);
    chk("t6_pc1", qget(deq_log, 1), 32'hFFFF_FFFC);
    chk("t6_plus4_wrap", qget(p4_log, 1), 32'h0);
    chk("t6_pc2", qget(deq_log, 2), 32'h0);
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    clear_logs();
    repeat (6) step();
    chk("t7_first_req", qget(req_log, 0), 32'h0);
    chk("t7_first_pc", qget(deq_log, 0), 32'h0);
    chk("t7_second_pc", qget(deq_log, 1), 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
